pc_redirect_unit: RTL

// - Consumer side of the branch-resolution interface: takes PCSrc/PCNew from the branch control and owns the PC register.
// - Advances PC by 4 each cycle, or loads the redirect target, and drives the IF/ID flush.
// - Buffers one redirect that arrives while the front end is stalled, then applies it when the stall releases.
// - Sits between the branch control (EX) and the instruction memory / IF-ID register.

---
 rtl/pc_redirect_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// PC register with branch redirect, IF/ID flush timing and one-deep
// buffering of a redirect that arrives while the front end is stalled.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCNew,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        RedirectPending,
    output logic        Misaligned,
    output logic [15:0] RedirectCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        PEND  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [31:0] pend_pc;
    logic [31:0] tgt;
    logic        redir;
    logic        mis_in;
    logic        apply_new;
    logic        apply_pend;
    logic        latch;
    logic        adv;
    logic        reload;
    logic        pend_nxt;

    assign redir   = (PCSrc == 2'b01);
    assign tgt     = {PCNew[31:2], 2'b00};
    assign mis_in  = |PCNew[1:0];
    assign PCPlus4 = PC + 32'd4;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A buffered target always takes priority; new redirects on that
    // edge are dropped so the first buffered target wins.
    always_comb begin
        apply_new  = 1'b0;
        apply_pend = 1'b0;
        latch      = 1'b0;
        adv        = 1'b0;
        unique case (state)
            PEND: begin
                apply_pend = !Stall;
            end
            FLUSH: begin
                if (RedirectPending) begin
                    apply_pend = !Stall;
                end else begin
                    apply_new = redir & !Stall;
                    latch     = redir & Stall;
                    adv       = !redir & !Stall;
                end
            end
            RUN, HOLD: begin
                apply_new = redir & !Stall;
                latch     = redir & Stall;
                adv       = !redir & !Stall;
            end
        endcase
    end

    assign reload   = apply_new | apply_pend;
    assign pend_nxt = latch | (RedirectPending & !apply_pend);

    always_comb begin
        cnt_nxt = 3'd0;
        if (reload) begin
            cnt_nxt = FC;
        end else if (cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (cnt_nxt != 3'd0) begin
            state_nxt = FLUSH;
        end else if (pend_nxt) begin
            state_nxt = PEND;
        end else if (Stall) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            PC              <= RESET_PC;
            cnt             <= 3'd0;
            Flush           <= 1'b0;
            RedirectPending <= 1'b0;
            pend_pc         <= 32'd0;
            Misaligned      <= 1'b0;
            RedirectCount   <= 16'd0;
        end else begin
            cnt             <= cnt_nxt;
            Flush           <= (cnt_nxt != 3'd0);
            RedirectPending <= pend_nxt;
            if (latch) begin
                pend_pc <= tgt;
            end
            if (apply_pend) begin
                PC <= pend_pc;
            end else if (apply_new) begin
                PC <= tgt;
            end else if (adv) begin
                PC <= PCPlus4;
            end
            if (reload) begin
                RedirectCount <= RedirectCount + 16'd1;
            end
            if ((apply_new | latch) & mis_in) begin
                Misaligned <= 1'b1;
            end
        end
    end

endmodule
